// File: rtl/lc3_datapath_mem_if.sv
// Memory handshake bundle between the LC-3 datapath (master) and the memory subsystem (slave).
interface lc3_datapath_mem_if;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport master (output mem_req, mem_wr, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_wr, mem_addr, mem_wdata,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/lc3_datapath_mem.sv
// LC-3 single-bus datapath with a handshaked memory engine (wait states + timeout),
// bus-contention detection and an LED register.
module lc3_datapath_mem #(
   parameter int          NUM_REGS    = 8,
   parameter int          LED_W       = 12,
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          MEM_TIMEOUT = 64
) (
   input  logic                i_Clk,
   input  logic                i_Reset,
   input  logic [3:0]          i_gate,      // {MARMUX,MDR,ALU,PC}
   input  logic [7:0]          i_ld,        // {IR,MAR,MDR,PC,CC,BEN,LED,REG}
   input  logic                i_SR1MUX,
   input  logic                i_SR2MUX,
   input  logic                i_DRMUX,
   input  logic                i_ADDR1MUX,
   input  logic [1:0]          i_PCMUX,
   input  logic [1:0]          i_ADDR2MUX,
   input  logic [1:0]          i_ALUK,
   input  logic                i_reg_bank,
   input  logic                i_mem_start,
   input  logic                i_mem_we,
   lc3_datapath_mem_if.master  mem,
   output logic                o_mem_done,
   output logic                o_mem_err,
   output logic                o_bus_conflict,
   output logic                o_BEN,
   output logic [2:0]          o_nzp,
   output logic [15:0]         o_PC,
   output logic [15:0]         o_IR,
   output logic [15:0]         o_MAR,
   output logic [15:0]         o_MDR,
   output logic [15:0]         o_bus,
   output logic [LED_W-1:0]    o_LED
);
   localparam int RW = $clog2(NUM_REGS);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [CW-1:0]       r_wcnt;
   logic                r_we, r_err, r_conf, r_ben;
   logic [2:0]          r_nzp;
   logic [15:0]         r_pc, r_ir, r_mar, r_mdr;
   logic [LED_W-1:0]    r_led;
   logic [15:0]         r_regs [NUM_REGS];

   logic                w_req, w_ack_rd, w_tmo, w_conflict;
   logic [3:0]          w_dr4, w_sr1_4, w_sr2_4;
   logic [RW-1:0]       w_dr, w_sr1, w_sr2;
   logic                w_unused_idx;
   logic [15:0]         w_sr1_val, w_sr2_val, w_alu_b, w_alu, w_addr1, w_addr2, w_adder, w_bus, w_pc_next;
   logic [2:0]          w_nzp_new;

   // Register indices: bit 3 comes from reg_bank and only survives when NUM_REGS=16.
   assign w_dr4   = {i_reg_bank, i_DRMUX  ? 3'd7 : r_ir[11:9]};
   assign w_sr1_4 = {i_reg_bank, i_SR1MUX ? r_ir[8:6] : r_ir[11:9]};
   assign w_sr2_4 = {i_reg_bank, r_ir[2:0]};
   assign w_dr    = w_dr4[RW-1:0];
   assign w_sr1   = w_sr1_4[RW-1:0];
   assign w_sr2   = w_sr2_4[RW-1:0];
   assign w_unused_idx = ^{w_dr4, w_sr1_4, w_sr2_4};

   assign w_sr1_val = r_regs[w_sr1];
   assign w_sr2_val = r_regs[w_sr2];
   assign w_alu_b   = i_SR2MUX ? {{11{r_ir[4]}}, r_ir[4:0]} : w_sr2_val;
   assign w_addr1   = i_ADDR1MUX ? w_sr1_val : r_pc;
   assign w_adder   = w_addr1 + w_addr2;
   assign w_conflict = (i_gate & (i_gate - 4'd1)) != 4'd0;
   assign w_nzp_new = w_bus[15] ? 3'b100 : ((w_bus == 16'h0) ? 3'b010 : 3'b001);

   // ALU, address-offset select, bus mux and PC source select.
   always_comb begin
      w_alu     = 16'h0;
      w_addr2   = 16'h0;
      w_bus     = 16'h0;
      w_pc_next = r_pc + 16'd1;
      case (i_ALUK)
         2'd0:    w_alu = w_sr1_val + w_alu_b;
         2'd1:    w_alu = w_sr1_val & w_alu_b;
         2'd2:    w_alu = ~w_sr1_val;
         default: w_alu = w_sr1_val;
      endcase
      case (i_ADDR2MUX)
         2'd1:    w_addr2 = {{10{r_ir[5]}},  r_ir[5:0]};
         2'd2:    w_addr2 = {{7{r_ir[8]}},   r_ir[8:0]};
         2'd3:    w_addr2 = {{5{r_ir[10]}},  r_ir[10:0]};
         default: w_addr2 = 16'h0;
      endcase
      case (i_gate)
         4'b0001: w_bus = r_pc;
         4'b0010: w_bus = w_alu;
         4'b0100: w_bus = r_mdr;
         4'b1000: w_bus = w_adder;
         default: w_bus = 16'h0;   // idle or contended bus reads as zero
      endcase
      case (i_PCMUX)
         2'd1:    w_pc_next = w_bus;
         2'd2:    w_pc_next = w_adder;
         default: w_pc_next = r_pc + 16'd1;
      endcase
   end

   // Memory engine next state; an ack on the last counted cycle wins over the timeout.
   always_comb begin
      w_next   = r_state;
      w_ack_rd = 1'b0;
      w_tmo    = 1'b0;
      case (r_state)
         S_IDLE: if (i_mem_start) w_next = S_REQ;
         S_REQ: begin
            if (mem.mem_ack) begin
               w_next   = S_DONE;
               w_ack_rd = !r_we;
            end else if (r_wcnt == CW'(MEM_TIMEOUT - 1)) begin
               w_next = S_DONE;
               w_tmo  = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Memory engine state, wait counter, latched direction and sticky error.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && i_mem_start) begin
            r_we   <= i_mem_we;
            r_err  <= 1'b0;
            r_wcnt <= '0;
         end
         if (r_state == S_REQ) r_wcnt <= r_wcnt + 1'b1;
         if (w_tmo) r_err <= 1'b1;
      end
   end

   assign w_req = (r_state == S_REQ);

   // Datapath registers; MAR/MDR are frozen while a request is outstanding.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         r_pc   <= RESET_PC;
         r_ir   <= 16'h0;
         r_mar  <= 16'h0;
         r_mdr  <= 16'h0;
         r_led  <= '0;
         r_nzp  <= 3'b000;
         r_ben  <= 1'b0;
         r_conf <= 1'b0;
      end else begin
         if (i_ld[7]) r_ir <= w_bus;
         if (i_ld[6] && !w_req) r_mar <= w_bus;
         if (w_ack_rd) r_mdr <= mem.mem_rdata;
         else if (i_ld[5] && !w_req) r_mdr <= w_bus;
         if (i_ld[4]) r_pc  <= w_pc_next;
         if (i_ld[3]) r_nzp <= w_nzp_new;
         if (i_ld[2]) r_ben <= |(r_ir[11:9] & r_nzp);
         if (i_ld[1]) r_led <= r_ir[LED_W-1:0];
         if (w_conflict) r_conf <= 1'b1;
      end
   end

   // General register file, written from the bus.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 16'h0;
      end else if (i_ld[0]) begin
         r_regs[w_dr] <= w_bus;
      end
   end

   assign mem.mem_req   = w_req;
   assign mem.mem_wr    = w_req && r_we;
   assign mem.mem_addr  = r_mar;
   assign mem.mem_wdata = r_mdr;

   assign o_mem_done     = (r_state == S_DONE);
   assign o_mem_err      = r_err;
   assign o_bus_conflict = r_conf;
   assign o_BEN          = r_ben;
   assign o_nzp          = r_nzp;
   assign o_PC           = r_pc;
   assign o_IR           = r_ir;
   assign o_MAR          = r_mar;
   assign o_MDR          = r_mdr;
   assign o_bus          = w_bus;
   assign o_LED          = r_led;
endmodule
